pipeline_control: RTL and testbench

PIPELINE_CONTROL -- requirements
Module: pipeline_control

---
 rtl/pipeline_control.sv | 75 +++++++
 tb/tb_pipeline_control.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/pipeline_control.sv
// pipeline_control: hazard/stall/flush controller for a 5-stage pipeline.
// Optional stall statistics counter enabled by defining PIPELINE_CONTROL_STATS_EN.
module pipeline_control (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  id_rs,
    input  logic [3:0]  id_rt,
    input  logic        id_usesRs,
    input  logic        id_usesRt,
    input  logic        ex_memRead,
    input  logic        ex_regWrite,
    input  logic [3:0]  ex_registerFileWrite,
    input  logic        ex_branch,
    input  logic        ex_branchTaken,
    input  logic        ex_jumpRegister,
    input  logic        mem_busy,
    output logic        pcWrite,
    output logic        ifIdWrite,
    output logic        ifIdFlush,
    output logic        idExBubble,
    output logic        pipeHold,
    output logic [15:0] stallCount
);
    typedef enum logic [1:0] {RUN, LOAD_STALL, FLUSH, MEM_WAIT} state_t;
    state_t r_state, w_next;
    logic w_redirect, w_load_use, w_lu_enabled;
    assign w_redirect = (ex_branch & ex_branchTaken) | ex_jumpRegister;
    assign w_load_use = ex_memRead & ex_regWrite & (ex_registerFileWrite != 4'd0) &
                        ((id_usesRs & (id_rs == ex_registerFileWrite)) |
                         (id_usesRt & (id_rt == ex_registerFileWrite)));
    // A released MEM_WAIT behaves exactly like RUN for the current cycle.
    assign w_lu_enabled = (r_state == RUN) || (r_state == MEM_WAIT);
    always_ff @(posedge clock) begin
        if (!reset) r_state <= RUN;
        else        r_state <= w_next;
    end
    always_comb begin
        pcWrite    = 1'b1;
        ifIdWrite  = 1'b1;
        ifIdFlush  = 1'b0;
        idExBubble = 1'b0;
        pipeHold   = 1'b0;
        w_next     = RUN;
        if (!reset) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            ifIdFlush  = 1'b1;
            idExBubble = 1'b1;
        end else if (mem_busy) begin
            pcWrite   = 1'b0;
            ifIdWrite = 1'b0;
            pipeHold  = 1'b1;
            w_next    = MEM_WAIT;
        end else if (w_redirect) begin
            ifIdFlush  = 1'b1;
            idExBubble = 1'b1;
            w_next     = FLUSH;
        end else if (w_load_use && w_lu_enabled) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            idExBubble = 1'b1;
            w_next     = LOAD_STALL;
        end
    end
`ifdef PIPELINE_CONTROL_STATS_EN
    logic [15:0] r_stall_count;
    always_ff @(posedge clock) begin
        if (!reset)                                  r_stall_count <= 16'd0;
        else if (!pcWrite && r_stall_count != 16'hFFFF) r_stall_count <= r_stall_count + 16'd1;
    end
    assign stallCount = r_stall_count;
`else
    assign stallCount = 16'd0;
`endif
endmodule

// File: tb/tb_pipeline_control.sv
// tb_pipeline_control: directed and randomized checks of pipeline_control against
// a rule-level model (which events stall, which cycle ignores load-use, stall tally).
module tb_pipeline_control;
    logic        clock = 1'b0, reset = 1'b0;
    logic [3:0]  id_rs = 0, id_rt = 0, ex_registerFileWrite = 0;
    logic        id_usesRs = 0, id_usesRt = 0, ex_memRead = 0, ex_regWrite = 0;
    logic        ex_branch = 0, ex_branchTaken = 0, ex_jumpRegister = 0, mem_busy = 0;
    logic        pcWrite, ifIdWrite, ifIdFlush, idExBubble, pipeHold;
    logic [15:0] stallCount;
    int errors = 0, checks = 0;
    bit m_sup = 1'b0;
    int m_count = 0;

    pipeline_control dut (
        .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_usesRs(id_usesRs), .id_usesRt(id_usesRt), .ex_memRead(ex_memRead),
        .ex_regWrite(ex_regWrite), .ex_registerFileWrite(ex_registerFileWrite),
        .ex_branch(ex_branch), .ex_branchTaken(ex_branchTaken),
        .ex_jumpRegister(ex_jumpRegister), .mem_busy(mem_busy), .pcWrite(pcWrite),
        .ifIdWrite(ifIdWrite), .ifIdFlush(ifIdFlush), .idExBubble(idExBubble),
        .pipeHold(pipeHold), .stallCount(stallCount)
    );

    always #5 clock = ~clock;

    function automatic logic hazard();
        return ex_memRead && ex_regWrite && ex_registerFileWrite != 0 &&
               ((id_usesRs && id_rs == ex_registerFileWrite) || (id_usesRt && id_rt == ex_registerFileWrite));
    endfunction

    function automatic logic redirect();
        return (ex_branch && ex_branchTaken) || ex_jumpRegister;
    endfunction

    // {pcWrite, ifIdWrite, ifIdFlush, idExBubble, pipeHold}
    function automatic logic [4:0] expected();
        if (!reset)                 return 5'b00110;
        if (mem_busy)               return 5'b00001;
        if (redirect())             return 5'b11110;
        if (hazard() && !m_sup)     return 5'b00010;
        return 5'b11000;
    endfunction

    function automatic int expected_count();
`ifdef PIPELINE_CONTROL_STATS_EN
        return m_count;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Load-use is ignored in the cycle right after a load stall or a redirect.
    always @(posedge clock) begin
        if (!reset) begin
            m_sup   <= 1'b0;
            m_count <= 0;
        end else begin
            m_sup <= !mem_busy && (redirect() || (hazard() && !m_sup));
            if (mem_busy || (!redirect() && hazard() && !m_sup))
                m_count <= (m_count == 65535) ? 65535 : m_count + 1;
        end
    end

    always @(negedge clock) begin
        chk("outputs", {27'd0, pcWrite, ifIdWrite, ifIdFlush, idExBubble, pipeHold}, {27'd0, expected()});
        chk("stallCount", {16'd0, stallCount}, expected_count());
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clr();
        {id_rs, id_rt, ex_registerFileWrite} = '0;
        {id_usesRs, id_usesRt, ex_memRead, ex_regWrite} = '0;
        {ex_branch, ex_branchTaken, ex_jumpRegister, mem_busy} = '0;
    endtask

    initial begin
        cyc(2);
        #2 chk("reset_outs", {pcWrite, ifIdWrite, ifIdFlush, idExBubble, pipeHold}, 5'b00110);
        chk("reset_count", stallCount, 0);
        cyc(1);
        reset = 1;
        ex_memRead = 1; ex_regWrite = 1; ex_registerFileWrite = 5; id_rs = 5; id_usesRs = 1;
        #2 chk("lu_stall_pc", pcWrite, 0);
        chk("lu_stall_bubble", idExBubble, 1);
        cyc(1);
        #2 chk("lu_hold_pc", pcWrite, 1);
        cyc(1);
        ex_memRead = 0;
        #2 chk("lu_run_pc", pcWrite, 1);
        cyc(1);
        ex_memRead = 1; ex_registerFileWrite = 0; id_rs = 0;
        #2 chk("r0_no_stall", pcWrite, 1);
        cyc(1);
        ex_registerFileWrite = 5; id_rs = 5; ex_jumpRegister = 1;
        #2 chk("jr_over_lu", {pcWrite, ifIdWrite, ifIdFlush, idExBubble, pipeHold}, 5'b11110);
        cyc(1);
        ex_jumpRegister = 0;
        #2 chk("flush_ignores_lu", pcWrite, 1);
        cyc(1);
        #2 chk("lu_after_flush", pcWrite, 0);
        cyc(1);
        clr();
        cyc(1);
        mem_busy = 1; ex_branch = 1; ex_branchTaken = 1;
        for (int i = 0; i < 3; i++) begin
            #2 chk("busy_hold", {pcWrite, pipeHold}, 2'b01);
            cyc(1);
        end
        mem_busy = 0;
        #2 chk("flush_after_busy", {pcWrite, ifIdFlush, idExBubble}, 3'b111);
`ifdef PIPELINE_CONTROL_STATS_EN
        chk("count_after_busy", stallCount, 5);
`endif
        cyc(1);
        clr();
        cyc(1);
        mem_busy = 1;
        cyc(1);
        reset = 0;
        #2 chk("reset_in_wait", {pcWrite, ifIdWrite, ifIdFlush, idExBubble, pipeHold}, 5'b00110);
        cyc(1);
        reset = 1; mem_busy = 0;
        #2 chk("run_after_reset", {pcWrite, ifIdWrite, ifIdFlush, idExBubble, pipeHold}, 5'b11000);
        chk("count_after_reset", stallCount, 0);
        for (int i = 0; i < 1500; i++) begin
            cyc(1);
            reset = $urandom_range(0, 49) != 0;
            mem_busy = $urandom_range(0, 4) == 0;
            id_rs = 4'($urandom_range(0, 3));
            id_rt = 4'($urandom_range(0, 3));
            ex_registerFileWrite = 4'($urandom_range(0, 3));
            id_usesRs = 1'($urandom);
            id_usesRt = 1'($urandom);
            ex_memRead = $urandom_range(0, 2) != 0;
            ex_regWrite = $urandom_range(0, 3) != 0;
            ex_branch = 1'($urandom);
            ex_branchTaken = $urandom_range(0, 5) == 0;
            ex_jumpRegister = $urandom_range(0, 11) == 0;
        end
`ifdef PIPELINE_CONTROL_STATS_EN
        cyc(1);
        clr();
        reset = 1; mem_busy = 1;
        cyc(70000);
        #2 chk("saturated", stallCount, 16'hFFFF);
        cyc(5);
        #2 chk("stays_saturated", stallCount, 16'hFFFF);
`endif
        cyc(1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
